lcd_frame_arbiter: RTL and testbench
====================================

Name: lcd_frame_arbiter

Overview:
- Shares the single LCD byte-write path between two frame sources. Source 0 is the game-field serializer; source 1 is the status/score panel serializer.
- Grants one source for a whole frame burst and passes its byte stream to the LCD controller under a valid/ready handshake.
- Round-robins between sources at frame boundaries, inserts a fixed inter-frame gap, and aborts a burst whose source stalls too long.
- Sits between the RAM-side serializers and LCD_control, in the clk_div (100 kHz) domain.

Parameters:
- BURST_BYTES, 1024, bytes per frame burst (2 chips x 8 pages x 64 columns).
- GAP_CYCLES, 8, idle cycles after each burst, before the next arbitration.
- TIMEOUT_CYCLES, 4096, maximum cycles without a handshake during XFER before the burst is aborted.

Ports:
- clk  in  1  block clock (clk_div domain).
- rst  in  1  asynchronous reset, active-high.
- src0_req  in  1  source 0 requests a frame.
- src0_data  in  8  source 0 byte.
- src0_valid  in  1  source 0 byte valid.
- src0_ready  out  1  byte from source 0 accepted this cycle.
- src1_req  in  1  source 1 requests a frame.
- src1_data  in  8  source 1 byte.
- src1_valid  in  1  source 1 byte valid.
- src1_ready  out  1  byte from source 1 accepted this cycle.
- gnt  out  2  one-hot grant, held for the entire burst.
- lcd_data  out  8  byte to LCD_control.data.
- lcd_data_valid  out  1  to LCD_control.data_valid.
- lcd_en_tran  in  1  LCD_control ready to accept a byte.
- frame_done  out  1  one-cycle pulse when a burst completes normally.
- frame_src  out  1  source index of the last completed or aborted burst.
- timeout_err  out  1  one-cycle pulse when a burst is aborted.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; gnt=2'b00.
  - lcd_data_valid=0, src*_ready=0, frame_done=0, timeout_err=0, frame_src=0.
  - Byte count=0, gap counter=0, timeout counter=0.
  - last_src=1, so source 0 wins the first tie.
- A handshake occurs on a cycle where lcd_data_valid=1 and lcd_en_tran=1.
- States:
  - IDLE:
    - Requests are sampled only here.
    - No request: stay in IDLE.
    - Exactly one request: register gnt for that source and go to XFER next cycle.
    - Both requests: grant the source other than last_src.
    - 1-cycle latency from req to gnt.
  - XFER:
    - lcd_data = granted srcN_data (combinational mux).
    - lcd_data_valid = granted srcN_valid.
    - Granted srcN_ready = lcd_en_tran & srcN_valid; the ungranted ready = 0.
    - Each handshake increments the byte count and clears the timeout counter. Cycles without a handshake increment the timeout counter.
    - Normal end: a handshake with count == BURST_BYTES-1 goes to GAP. Same cycle: frame_done=1, frame_src=granted index, last_src=granted index.
    - Abort: timeout counter reaches TIMEOUT_CYCLES-1 with no handshake goes to GAP. Same cycle: timeout_err=1, frame_src=granted index, last_src=granted index, frame_done=0.
    - A handshake on the same cycle as the timeout limit counts as progress: no abort.
  - GAP:
    - gnt=0, lcd_data_valid=0, both readys=0.
    - Count GAP_CYCLES, then return to IDLE.
    - Byte count and timeout counter clear on entry.
- Outside XFER, lcd_data=8'h00 and lcd_data_valid=0.
- The req input of the granted source is ignored during XFER. Dropping it mid-burst does not end the burst; only completion or timeout does.
- A request asserted during XFER or GAP is held off until IDLE. Requests are level-sensitive, so nothing is lost as long as req stays high.
- Counter widths: byte count ceil(log2(BURST_BYTES)) bits; timeout counter ceil(log2(TIMEOUT_CYCLES)) bits; gap counter ceil(log2(GAP_CYCLES+1)) bits. None of them wrap, because each clears at its terminal value.
- Async reset mid-burst: return immediately to the reset values listed above. No frame_done or timeout_err pulse is produced.

Test Plan:
- Bench parameters for all scenarios: BURST_BYTES=8, GAP_CYCLES=3, TIMEOUT_CYCLES=16.
- Scenario 1, single source:
  - Stimulus: src0_req=1, src0_valid=1, lcd_en_tran=1, data 0x10..0x17.
  - Required: gnt=01 one cycle after req.
  - Required: lcd_data carries 0x10..0x17 on 8 consecutive cycles.
  - Required: frame_done pulses with the 8th byte, frame_src=0, then 3 gap cycles with gnt=00.
- Scenario 2, simultaneous requests:
  - Stimulus: src0_req=src1_req=1 held continuously.
  - Required: grants alternate 01, 10, 01 across three bursts; first grant to source 0.
  - Required: exactly 3 idle gap cycles plus 1 arbitration cycle between bursts.
- Scenario 3, backpressure:
  - Stimulus: lcd_en_tran toggled 1,0,1,0 during a source 1 burst.
  - Required: src1_ready mirrors lcd_en_tran.
  - Required: no byte is dropped or duplicated; frame_done arrives after exactly 8 handshakes.
- Scenario 4, timeout:
  - Stimulus: source 0 sends 3 bytes, then src0_valid=0 for 16 cycles.
  - Required: timeout_err pulses on the 16th stall cycle, frame_src=0, no frame_done.
  - Required: a pending src1_req is granted immediately after the gap.
- Scenario 5, request dropped mid-burst:
  - Stimulus: src0_req deasserted after byte 2.
  - Required: the burst still completes all 8 bytes and frame_done pulses.
- Scenario 6, reset mid-burst:
  - Stimulus: rst pulsed after byte 4 of a source 1 burst.
  - Required: gnt=00 and lcd_data_valid=0 asynchronously, with no frame_done.
  - Required: the next simultaneous request grants source 0 first.

Source files
------------

// File: rtl/lcd_frame_arbiter.sv
// Two-source frame arbiter for the LCD byte-write path: grants one serializer for a
// whole burst, round-robins at frame boundaries, and aborts bursts that stall too long.
module lcd_frame_arbiter #(
  parameter int BURST_BYTES    = 1024,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       src0_req,
  input  logic [7:0] src0_data,
  input  logic       src0_valid,
  output logic       src0_ready,
  input  logic       src1_req,
  input  logic [7:0] src1_data,
  input  logic       src1_valid,
  output logic       src1_ready,
  output logic [1:0] gnt,
  output logic [7:0] lcd_data,
  output logic       lcd_data_valid,
  input  logic       lcd_en_tran,
  output logic       frame_done,
  output logic       frame_src,
  output logic       timeout_err
);

  localparam int BW = (BURST_BYTES > 1) ? $clog2(BURST_BYTES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(BURST_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_src_q, last_src_d;
  logic          frame_src_q, frame_src_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  logic       gnt_idx;
  logic       sel_valid;
  logic [7:0] sel_data;
  logic       hs;
  logic       end_burst;

  // gnt_q is one-hot whenever the FSM is in XFER, so bit 1 alone names the source
  assign gnt_idx   = gnt_q[1];
  assign sel_valid = gnt_idx ? src1_valid : src0_valid;
  assign sel_data  = gnt_idx ? src1_data : src0_data;
  assign hs        = (state_q == S_XFER) & sel_valid & lcd_en_tran;
  assign gnt       = gnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'b00;
      last_src_q  <= 1'b1;
      frame_src_q <= 1'b0;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_src_q  <= last_src_d;
      frame_src_q <= frame_src_d;
      byte_cnt_q  <= byte_cnt_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    last_src_d     = last_src_q;
    frame_src_d    = frame_src_q;
    byte_cnt_d     = byte_cnt_q;
    to_cnt_d       = to_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    lcd_data       = 8'h00;
    lcd_data_valid = 1'b0;
    src0_ready     = 1'b0;
    src1_ready     = 1'b0;
    frame_done     = 1'b0;
    timeout_err    = 1'b0;
    frame_src      = frame_src_q;
    end_burst      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (src0_req | src1_req) begin
          if (src0_req & src1_req) gnt_d = last_src_q ? 2'b01 : 2'b10;
          else                     gnt_d = src0_req ? 2'b01 : 2'b10;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        lcd_data       = sel_data;
        lcd_data_valid = sel_valid;
        src0_ready     = gnt_q[0] & lcd_en_tran & src0_valid;
        src1_ready     = gnt_q[1] & lcd_en_tran & src1_valid;
        // a handshake on the timeout-limit cycle is progress, so it is checked first
        if (hs) begin
          to_cnt_d = '0;
          if (byte_cnt_q == BYTE_LAST) begin
            frame_done = 1'b1;
            end_burst  = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          timeout_err = 1'b1;
          end_burst   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
        if (end_burst) begin
          state_d     = S_GAP;
          gnt_d       = 2'b00;
          last_src_d  = gnt_idx;
          frame_src_d = gnt_idx;
          frame_src   = gnt_idx;
          byte_cnt_d  = '0;
          to_cnt_d    = '0;
          gap_cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Scoreboard bench for lcd_frame_arbiter: directed scenarios push expected bytes and
// end-of-burst events; a negedge monitor pops and compares whatever the DUT presents.
module tb_lcd_frame_arbiter;
  localparam int BB = 8;
  localparam int GC = 3;
  localparam int TC = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       src0_req, src0_valid, src0_ready;
  logic       src1_req, src1_valid, src1_ready;
  logic [7:0] src0_data, src1_data, lcd_data;
  logic [1:0] gnt;
  logic       lcd_data_valid, lcd_en_tran, frame_done, frame_src, timeout_err;

  lcd_frame_arbiter #(.BURST_BYTES(BB), .GAP_CYCLES(GC), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst(rst),
    .src0_req(src0_req), .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src1_req(src1_req), .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
    .gnt(gnt), .lcd_data(lcd_data), .lcd_data_valid(lcd_data_valid), .lcd_en_tran(lcd_en_tran),
    .frame_done(frame_done), .frame_src(frame_src), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem0 [8];
  logic [7:0] mem1 [8];
  int ptr0 = 0, ptr1 = 0, lim0 = 8, lim1 = 8;
  bit en0 = 1'b0, en1 = 1'b0;
  logic [8:0] exp_bytes [$];
  logic [2:0] exp_evt [$];   // {frame_done, timeout_err, frame_src}
  int hs_count = 0;
  int evt_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic update_src();
    src0_valid = en0 && (ptr0 < lim0);
    src1_valid = en1 && (ptr1 < lim1);
    src0_data  = (ptr0 < 8) ? mem0[ptr0] : 8'h00;
    src1_data  = (ptr1 < 8) ? mem1[ptr1] : 8'h00;
  endtask

  // One clock: sample readys away from the edge, then advance the source models.
  task automatic cycle();
    bit t0, t1;
    @(negedge clk);
    t0 = src0_ready;
    t1 = src1_ready;
    @(posedge clk);
    #1;
    if (t0) ptr0++;
    if (t1) ptr1++;
    update_src();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input bit src, input logic [7:0] base, input int nexp, input int lim);
    for (int i = 0; i < 8; i++) begin
      if (src) mem1[i] = base + 8'(i);
      else     mem0[i] = base + 8'(i);
    end
    if (src) begin ptr1 = 0; lim1 = lim; en1 = 1'b1; end
    else     begin ptr0 = 0; lim0 = lim; en0 = 1'b1; end
    for (int i = 0; i < nexp; i++) exp_bytes.push_back({src, base + 8'(i)});
    update_src();
  endtask

  task automatic wait_gnt(input string name, input int budget, output int n);
    n = 0;
    while (gnt == 2'b00 && n < budget) begin cycle(); n++; end
    if (gnt == 2'b00) begin
      errors++; checks++;
      $display("FAIL %s: no grant within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_evt(input string name, input int budget, input bit toggle, output int n);
    int start;
    start = evt_count;
    n = 0;
    while (evt_count == start && n < budget) begin
      if (toggle) lcd_en_tran = ~lcd_en_tran;
      cycle();
      n++;
    end
    if (evt_count == start) begin
      errors++; checks++;
      $display("FAIL %s: no end-of-burst event within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_hs(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (hs_count < target && n < budget) begin cycle(); n++; end
    if (hs_count < target) begin
      errors++; checks++;
      $display("FAIL %s: handshakes %0d expected %0d", name, hs_count, target);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_valid"}, 32'(lcd_data_valid), 32'd0);
    check({tag, "_ready"}, 32'({src0_ready, src1_ready}), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_tmo"}, 32'(timeout_err), 32'd0);
    check({tag, "_fsrc"}, 32'(frame_src), 32'd0);
  endtask

  // Scoreboard monitor
  initial begin
    logic [8:0] eb;
    logic [2:0] ee;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        check("ready0", 32'(src0_ready), 32'(gnt[0] & lcd_en_tran & src0_valid));
        check("ready1", 32'(src1_ready), 32'(gnt[1] & lcd_en_tran & src1_valid));
        if (lcd_data_valid && lcd_en_tran) begin
          hs_count++;
          if (exp_bytes.size() == 0) begin
            errors++; checks++;
            $display("FAIL byte_unexpected: got %0h from gnt %b, none expected", lcd_data, gnt);
          end else begin
            eb = exp_bytes.pop_front();
            check("byte_data", 32'(lcd_data), 32'(eb[7:0]));
            check("byte_gnt", 32'(gnt), eb[8] ? 32'd2 : 32'd1);
          end
        end
        if (frame_done || timeout_err) begin
          evt_count++;
          if (exp_evt.size() == 0) begin
            errors++; checks++;
            $display("FAIL evt_unexpected: got done=%b tmo=%b src=%b", frame_done, timeout_err, frame_src);
          end else begin
            ee = exp_evt.pop_front();
            check("evt", 32'({frame_done, timeout_err, frame_src}), 32'(ee));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst = 1'b1; src0_req = 1'b0; src1_req = 1'b0; lcd_en_tran = 1'b1;
    for (int i = 0; i < 8; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
    update_src();
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b0;
    cycle();

    // Scenario 1: single source, 8 bytes, then 3 gap cycles
    load(1'b0, 8'h10, 8, 8);
    exp_evt.push_back(3'b100);
    src0_req = 1'b1;
    cycle();
    check("s1_gnt_latency", 32'(gnt), 32'd1);
    src0_req = 1'b0;
    wait_evt("s1_done", 40, 1'b0, n);
    check("s1_burst_cycles", 32'(n), 32'd8);
    for (int i = 0; i < GC; i++) begin
      check("s1_gap_gnt", 32'(gnt), 32'd0);
      cycle();
    end
    idle(3);

    // Scenario 2: simultaneous requests alternate grants, starting from source 0
    rst = 1'b1; #1; rst = 1'b0;
    load(1'b0, 8'h20, 8, 8);
    load(1'b1, 8'h30, 8, 8);
    exp_evt.push_back(3'b100);
    exp_evt.push_back(3'b101);
    exp_evt.push_back(3'b100);
    src0_req = 1'b1; src1_req = 1'b1;
    cycle();
    check("s2_gnt_a", 32'(gnt), 32'd1);
    wait_evt("s2_done_a", 40, 1'b0, n);
    load(1'b0, 8'h40, 8, 8);
    wait_gnt("s2_gnt_b", 20, n);
    check("s2_gap_b", 32'(n), 32'(GC + 1));
    check("s2_gnt_b", 32'(gnt), 32'd2);
    wait_evt("s2_done_b", 40, 1'b0, n);
    wait_gnt("s2_gnt_c", 20, n);
    check("s2_gap_c", 32'(n), 32'(GC + 1));
    check("s2_gnt_c", 32'(gnt), 32'd1);
    src0_req = 1'b0; src1_req = 1'b0;
    wait_evt("s2_done_c", 40, 1'b0, n);
    idle(5);

    // Scenario 3: backpressure on a source 1 burst
    load(1'b1, 8'h50, 8, 8);
    exp_evt.push_back(3'b101);
    src1_req = 1'b1;
    cycle();
    check("s3_gnt", 32'(gnt), 32'd2);
    src1_req = 1'b0;
    base = hs_count;
    lcd_en_tran = 1'b0;
    wait_evt("s3_done", 60, 1'b1, n);
    check("s3_burst_cycles", 32'(n), 32'd15);
    check("s3_hs", 32'(hs_count - base), 32'd8);
    lcd_en_tran = 1'b1;
    idle(5);

    // Scenario 4: source 0 stalls after 3 bytes; pending source 1 follows the gap
    load(1'b0, 8'h60, 3, 3);
    exp_evt.push_back(3'b010);
    src0_req = 1'b1;
    cycle();
    check("s4_gnt", 32'(gnt), 32'd1);
    src0_req = 1'b0;
    load(1'b1, 8'h68, 8, 8);
    exp_evt.push_back(3'b101);
    src1_req = 1'b1;
    wait_evt("s4_timeout", 60, 1'b0, n);
    check("s4_timeout_cycles", 32'(n), 32'(3 + TC));
    wait_gnt("s4_gnt1", 20, n);
    check("s4_gap", 32'(n), 32'(GC + 1));
    check("s4_gnt1", 32'(gnt), 32'd2);
    src1_req = 1'b0;
    wait_evt("s4_done1", 40, 1'b0, n);
    idle(5);

    // Scenario 5: request dropped after byte 2 does not end the burst
    load(1'b0, 8'h70, 8, 8);
    exp_evt.push_back(3'b100);
    src0_req = 1'b1;
    base = hs_count;
    cycle();
    check("s5_gnt", 32'(gnt), 32'd1);
    wait_hs("s5_hs2", base + 2, 20);
    src0_req = 1'b0;
    wait_evt("s5_done", 40, 1'b0, n);
    check("s5_hs", 32'(hs_count - base), 32'd8);
    idle(5);

    // Scenario 6: reset after byte 4 of a source 1 burst
    load(1'b1, 8'h80, 4, 8);
    src1_req = 1'b1;
    base = hs_count;
    cycle();
    check("s6_gnt", 32'(gnt), 32'd2);
    wait_hs("s6_hs4", base + 4, 20);
    rst = 1'b1;
    #1;
    reset_checks("s6_reset");
    cycle();
    rst = 1'b0;
    src1_req = 1'b0;
    cycle();
    load(1'b0, 8'h90, 8, 8);
    load(1'b1, 8'hA0, 0, 8);
    exp_evt.push_back(3'b100);
    src0_req = 1'b1; src1_req = 1'b1;
    cycle();
    check("s6_gnt_after_reset", 32'(gnt), 32'd1);
    src0_req = 1'b0; src1_req = 1'b0;
    wait_evt("s6_done", 40, 1'b0, n);
    idle(5);

    check("left_bytes", 32'(exp_bytes.size()), 32'd0);
    check("left_evts", 32'(exp_evt.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
